// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and the odd-parity frame check.
package ps2_pkg;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

    // bits = {parity, data[7:0]}; a good frame has an odd number of ones
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through scan-code queue with wrap-bit pointers.
module ps2_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    // a pop in the same cycle frees the slot the push needs
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_kbd_receiver.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames,
// validates them and queues scan codes for the host.
module ps2_kbd_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   prev_clk_reg;
    logic                   fall_reg;
    logic                   sample_reg;
    logic [3:0]             bit_cnt_reg;
    logic [9:0]             shift_reg;
    logic [IDLE_W-1:0]      idle_cnt_reg;
    logic                   overflow_reg;

    logic frame_done;
    logic frame_valid;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic drop;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        clk_sync_reg[gi]  <= 1'b1;
                        data_sync_reg[gi] <= 1'b1;
                    end else begin
                        clk_sync_reg[gi]  <= ps2_clk;
                        data_sync_reg[gi] <= ps2_data;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) begin
                        clk_sync_reg[gi]  <= 1'b1;
                        data_sync_reg[gi] <= 1'b1;
                    end else begin
                        clk_sync_reg[gi]  <= clk_sync_reg[gi-1];
                        data_sync_reg[gi] <= data_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // data is registered alongside the edge pulse so both line up
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_clk_reg <= 1'b1;
            fall_reg     <= 1'b0;
            sample_reg   <= 1'b1;
        end else begin
            prev_clk_reg <= clk_sync_reg[SYNC_STAGES-1];
            fall_reg     <= prev_clk_reg && !clk_sync_reg[SYNC_STAGES-1];
            sample_reg   <= data_sync_reg[SYNC_STAGES-1];
        end
    end

    assign frame_done  = fall_reg && (bit_cnt_reg == STOP_IDX);
    assign frame_valid = frame_done && !shift_reg[0] && sample_reg &&
                         odd_parity_ok(shift_reg[9:1]);
    assign pop         = !nextdata_n && !fifo_empty;
    assign drop        = frame_valid && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            idle_cnt_reg <= '0;
        end else if (fall_reg) begin
            idle_cnt_reg <= '0;
            if (bit_cnt_reg == STOP_IDX) begin
                bit_cnt_reg <= '0;
            end else begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                shift_reg   <= {sample_reg, shift_reg[9:1]};
            end
        end else begin
            if (idle_cnt_reg != IDLE_W'(TIMEOUT_CYCLES)) begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end else if (bit_cnt_reg != '0) begin
                bit_cnt_reg <= '0;
            end
        end
    end

    // sticky until the consumer pops, regardless of when space frees up
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (pop) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (frame_valid),
        .pop   (pop),
        .wdata (shift_reg[8:1]),
        .rdata (data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ready    = !fifo_empty;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_ps2_kbd_receiver.sv
// Directed bench for ps2_kbd_receiver with an inline behavioural keyboard.
module tb_ps2_kbd_receiver;
    import ps2_pkg::*;

    localparam int FD = 8;
    localparam int SS = 2;
    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ps2_kbd_receiver #(
        .FIFO_DEPTH     (FD),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow)
    );

    function automatic logic [10:0] make_frame(input logic [7:0] code,
                                               input logic par_flip,
                                               input logic stop);
        return {stop, (~^code) ^ par_flip, code, 1'b0};
    endfunction

    // bits start on a negedge of clk; 60 ns multiples keep edges there
    task automatic kbd_bits(input logic [10:0] frame, input int nbits);
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            #60 ps2_clk = 1'b0;
            #60 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic kbd_sendcode(input logic [7:0] code);
        kbd_bits(make_frame(code, 1'b0, 1'b1), PS2_FRAME_BITS);
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk) nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0 || overflow !== 1'b0 || data !== 8'h00) begin
            $display("FAIL reset: ready=%b overflow=%b data=%h, want 0 0 00", ready, overflow, data);
            n_bad++;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset: ready=%b overflow=%b data=%h", ready, overflow, data);
    endtask

    task automatic test_single();
        logic [10:0] f;
        f = make_frame(8'h1C, 1'b0, 1'b1);
        kbd_bits(f, 10);
        ps2_data = f[10];
        #60 ps2_clk = 1'b0;
        repeat (SS + 2) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            $display("FAIL single_latency: ready=%b want 1", ready);
            n_bad++;
        end
        n_cmp++;
        if (data !== 8'h1C) begin
            $display("FAIL single_data: data=%h want 1c", data);
            n_bad++;
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            $display("FAIL single_ovf: overflow=%b want 0", overflow);
            n_bad++;
        end
        @(negedge clk);
        #20 ps2_clk = 1'b1;
        ps2_data = 1'b1;
        pop_one();
        n_cmp++;
        if (ready !== 1'b0) begin
            $display("FAIL single_pop: ready=%b want 0", ready);
            n_bad++;
        end
        $display("single: code 1c received and popped");
    endtask

    task automatic test_sequence();
        logic [7:0] seq [9];
        seq = '{8'h1C, PS2_BREAK_CODE, 8'h1C, 8'h1B, PS2_BREAK_CODE, 8'h1B,
                8'h1B, PS2_BREAK_CODE, 8'h1B};
        for (int i = 0; i < 9; i++) begin
            kbd_sendcode(seq[i]);
            n_cmp++;
            if (ready !== 1'b1 || data !== seq[i]) begin
                $display("FAIL seq[%0d]: ready=%b data=%h want 1 %h", i, ready, data, seq[i]);
                n_bad++;
            end
            pop_one();
            $display("seq[%0d]: got %h", i, data);
        end
        n_cmp++;
        if (overflow !== 1'b0 || ready !== 1'b0) begin
            $display("FAIL seq_end: overflow=%b ready=%b want 0 0", overflow, ready);
            n_bad++;
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) kbd_sendcode(8'(i));
        n_cmp++;
        if (overflow !== 1'b1 || data !== 8'h01 || ready !== 1'b1) begin
            $display("FAIL ovf_set: overflow=%b data=%h ready=%b want 1 01 1", overflow, data, ready);
            n_bad++;
        end
        for (int i = 0; i < FD; i++) begin
            n_cmp++;
            if (data !== 8'(i + 1)) begin
                $display("FAIL ovf_pop[%0d]: data=%h want %h", i, data, 8'(i + 1));
                n_bad++;
            end
            pop_one();
            if (i == 0) begin
                n_cmp++;
                if (overflow !== 1'b0) begin
                    $display("FAIL ovf_clear: overflow=%b want 0", overflow);
                    n_bad++;
                end
            end
            $display("ovf_pop[%0d]: overflow=%b ready=%b", i, overflow, ready);
        end
        n_cmp++;
        if (ready !== 1'b0) begin
            $display("FAIL ovf_drained: ready=%b want 0", ready);
            n_bad++;
        end
    endtask

    task automatic test_bad_frames();
        kbd_bits(make_frame(8'h1C, 1'b1, 1'b1), PS2_FRAME_BITS);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0) begin
            $display("FAIL bad_parity: ready=%b want 0", ready);
            n_bad++;
        end
        kbd_bits(make_frame(8'h1C, 1'b0, 1'b0), PS2_FRAME_BITS);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0) begin
            $display("FAIL bad_stop: ready=%b want 0", ready);
            n_bad++;
        end
        kbd_sendcode(8'h1B);
        n_cmp++;
        if (ready !== 1'b1 || data !== 8'h1B) begin
            $display("FAIL bad_recover: ready=%b data=%h want 1 1b", ready, data);
            n_bad++;
        end
        pop_one();
        $display("bad_frames: two rejected, then 1b accepted");
    endtask

    task automatic test_timeout();
        kbd_bits(make_frame(8'h55, 1'b0, 1'b1), 5);
        repeat (TO + 50) @(negedge clk);
        kbd_sendcode(8'h2A);
        n_cmp++;
        if (ready !== 1'b1 || data !== 8'h2A) begin
            $display("FAIL timeout: ready=%b data=%h want 1 2a", ready, data);
            n_bad++;
        end
        pop_one();
        $display("timeout: partial frame discarded, got %h", 8'h2A);
    endtask

    task automatic test_reset_midframe();
        kbd_sendcode(8'h11);
        kbd_sendcode(8'h22);
        kbd_bits(make_frame(8'h3C, 1'b0, 1'b1), 4);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        n_cmp++;
        if (ready !== 1'b0 || overflow !== 1'b0 || data !== 8'h00) begin
            $display("FAIL rst_mid: ready=%b overflow=%b data=%h want 0 0 00", ready, overflow, data);
            n_bad++;
        end
        kbd_sendcode(8'h1C);
        n_cmp++;
        if (ready !== 1'b1 || data !== 8'h1C) begin
            $display("FAIL rst_recover: ready=%b data=%h want 1 1c", ready, data);
            n_bad++;
        end
        pop_one();
        n_cmp++;
        if (ready !== 1'b0) begin
            $display("FAIL rst_recover_pop: ready=%b want 0", ready);
            n_bad++;
        end
        $display("rst_mid: queue flushed, 1c received afterwards");
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_overflow();
        test_bad_frames();
        test_timeout();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
